// File: rtl/sm_imem_arbiter.sv
// Arbitrates one synchronous-read program memory between CPU fetch and a debug/loader port.
// Fetch has priority. Debug wins after MAX_WAIT contended cycles, and can lock out fetch for bulk loads.
module sm_imem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          cpu_stall,
  // debug/loader port
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_locked,
  // memory macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic          r_f_rvalid, r_d_rvalid;
  logic          w_f_gnt, w_d_gnt;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_f_gnt        = 1'b0;
    w_d_gnt        = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    case (r_state)
      ST_NORMAL: begin
        w_d_gnt = d_req & (~f_req | (r_wait_cnt >= MAX_WAIT_C));
        w_f_gnt = f_req & ~w_d_gnt;
        if (d_req && !w_d_gnt) begin
          w_wait_cnt_nxt = (r_wait_cnt >= MAX_WAIT_C) ? MAX_WAIT_C : r_wait_cnt + CW'(1);
        end
        if (w_d_gnt && d_lock) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Fetch stays blocked through the unlock cycle; the FSM only leaves at the next edge.
        w_d_gnt = d_req;
        if (!d_lock) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_wait_cnt <= '0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_f_rvalid <= w_f_gnt;
      r_d_rvalid <= w_d_gnt & ~d_we;
    end
  end

  assign f_gnt     = w_f_gnt;
  assign d_gnt     = w_d_gnt;
  assign cpu_stall = f_req & ~w_f_gnt;
  assign f_rvalid  = r_f_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign f_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign d_locked  = (r_state == ST_LOCKED);
  assign mem_en    = w_f_gnt | w_d_gnt;
  assign mem_we    = w_d_gnt & d_we;
  assign mem_addr  = w_f_gnt ? f_addr : d_addr;
  assign mem_wdata = d_wdata;

endmodule
